// File: rtl/multi_port_job_arbiter_if.sv
// Handshake bundle for the multi-port job arbiter.
// Master drives jobs and pops; slave is the arbiter itself.
interface multi_port_job_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int PORTS = 4
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS*WIDTH-1:0] in_data_i;
    logic [PORTS-1:0]       in_valid_i;
    logic [PORTS-1:0]       in_ack_o;
    logic [PORTS-1:0]       in_ready_o;
    logic [WIDTH-1:0]       out_data_o;
    logic                   out_valid_o;
    logic [PW-1:0]          out_port_o;
    logic                   out_pop_i;

    modport master (
        output in_data_i, in_valid_i, out_pop_i,
        input  in_ack_o, in_ready_o,
        input  out_data_o, out_valid_o, out_port_o
    );

    modport slave (
        input  in_data_i, in_valid_i, out_pop_i,
        output in_ack_o, in_ready_o,
        output out_data_o, out_valid_o, out_port_o
    );
endinterface

// File: rtl/multi_port_job_arbiter.sv
// Per-port job FIFOs feeding a single show-ahead output.
// Strict-priority or round-robin grant; a held grant is never preempted.
module multi_port_job_arbiter #(
    parameter int WIDTH = 4,
    parameter int PORTS = 4,
    parameter int DEPTH = 32,
    parameter int MODE  = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    multi_port_job_arbiter_if.slave   bus
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [PORTS][DEPTH];
    logic [AW-1:0]    wr_ptr [PORTS];
    logic [AW-1:0]    rd_ptr [PORTS];
    logic [AW:0]      cnt    [PORTS];

    logic [PORTS-1:0] push;
    logic [PORTS-1:0] pop;
    logic [PORTS-1:0] ready;
    logic [PORTS-1:0] elig;
    logic             pop_en;
    logic             any_elig;
    logic             found;
    logic             load;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    grant_q;
    logic [PW-1:0]    last_q;

    assign pop_en        = (state_q == GRANT) && bus.out_pop_i;
    assign bus.in_ack_o   = push;
    assign bus.in_ready_o = ready;

    // Per-port push/pop strobes and eligibility (pre-pop fullness).
    always_comb begin
        push = '0;
        pop  = '0;
        ready = '0;
        elig = '0;
        for (int k = 0; k < PORTS; k++) begin
            ready[k] = (cnt[k] != FULL);
            push[k]  = bus.in_valid_i[k] & ready[k] & rst_n_i;
            pop[k]   = pop_en && (grant_q == PW'(k));
            elig[k]  = (cnt[k] != '0) &&
                       !(pop[k] && (cnt[k] == (AW+1)'(1)));
        end
    end

    // Winner select: lowest index, or first after last_grant.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        any_elig = |elig;
        if (MODE == 0) begin
            for (int k = 0; k < PORTS; k++) begin
                if (!found && elig[k]) begin
                    winner = PW'(k);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= PORTS; i++) begin
                int j;
                j = (int'(last_q) + i) % PORTS;
                if (!found && elig[j]) begin
                    winner = PW'(j);
                    found  = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and grant-load decision.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    load    = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.out_pop_i) begin
                    if (any_elig) load = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output view of the granted FIFO head.
    always_comb begin
        bus.out_valid_o = (state_q == GRANT);
        bus.out_port_o  = grant_q;
        bus.out_data_o  = '0;
        if (state_q == GRANT)
            bus.out_data_o = mem[grant_q][rd_ptr[grant_q]];
    end

    // Grant and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q <= '0;
            last_q  <= PW'(PORTS-1);
        end else if (load) begin
            grant_q <= winner;
            last_q  <= winner;
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < PORTS; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                if (push[k] && !pop[k])
                    cnt[k] <= cnt[k] + 1'b1;
                else if (!push[k] && pop[k])
                    cnt[k] <= cnt[k] - 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < PORTS; k++) begin
            if (push[k])
                mem[k][wr_ptr[k]] <= bus.in_data_i[k*WIDTH +: WIDTH];
        end
    end
endmodule

// File: tb/tb_multi_port_job_arbiter.sv
// Directed bench for multi_port_job_arbiter.
// Two instances: strict priority (a0) and round-robin (a1).
module tb_multi_port_job_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;
    int   exp_i;

    always #5 clk = ~clk;

    multi_port_job_arbiter_if #(.WIDTH(8), .PORTS(4)) a0 ();
    multi_port_job_arbiter_if #(.WIDTH(8), .PORTS(4)) a1 ();

    multi_port_job_arbiter #(
        .WIDTH(8), .PORTS(4), .DEPTH(32), .MODE(0)
    ) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(a0)
    );

    multi_port_job_arbiter #(
        .WIDTH(8), .PORTS(4), .DEPTH(32), .MODE(1)
    ) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(a1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a0.in_valid_i = '0;
        a0.in_data_i  = '0;
        a0.out_pop_i  = 1'b0;
        a1.in_valid_i = '0;
        a1.in_data_i  = '0;
        a1.out_pop_i  = 1'b0;

        // reset state, with a push attempt that must not be acked
        a0.in_valid_i = 4'hf;
        #3;
        chk("rst_ack", 32'(a0.in_ack_o), 32'h0);
        chk("rst_ready", 32'(a0.in_ready_o), 32'hf);
        chk("rst_valid", 32'(a0.out_valid_o), 32'h0);
        chk("rst_port", 32'(a0.out_port_o), 32'h0);
        chk("rst_data", 32'(a0.out_data_o), 32'h0);
        a0.in_valid_i = '0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // round-robin fairness on a1
        for (int p = 0; p < 3; p++) begin
            a1.in_valid_i = 4'hf;
            for (int k = 0; k < 4; k++)
                a1.in_data_i[k*8 +: 8] = 8'(k*16 + p);
            #1;
            chk("rr_ack", 32'(a1.in_ack_o), 32'hf);
            tick;
        end
        a1.in_valid_i = '0;
        a1.out_pop_i  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk("rr_valid", 32'(a1.out_valid_o), 32'h1);
            chk("rr_port", 32'(a1.out_port_o), 32'(c % 4));
            chk("rr_data", 32'(a1.out_data_o),
                32'((c % 4) * 16 + c / 4));
            tick;
        end
        chk("rr_end", 32'(a1.out_valid_o), 32'h0);
        a1.out_pop_i = 1'b0;

        // strict mode, concurrent push on ports 2 and 0
        a0.in_valid_i = 4'b0101;
        a0.in_data_i  = '0;
        a0.in_data_i[23:16] = 8'h0a;
        a0.in_data_i[7:0]   = 8'h0b;
        #1;
        chk("sp_ack", 32'(a0.in_ack_o), 32'h5);
        tick;
        a0.in_valid_i = '0;
        chk("sp_lat1", 32'(a0.out_valid_o), 32'h0);
        tick;
        chk("sp_valid", 32'(a0.out_valid_o), 32'h1);
        chk("sp_data0", 32'(a0.out_data_o), 32'h0b);
        chk("sp_port0", 32'(a0.out_port_o), 32'h0);
        a0.out_pop_i = 1'b1;
        tick;
        chk("sp_data2", 32'(a0.out_data_o), 32'h0a);
        chk("sp_port2", 32'(a0.out_port_o), 32'h2);
        tick;
        a0.out_pop_i = 1'b0;
        chk("sp_idle", 32'(a0.out_valid_o), 32'h0);

        // no preemption: port 3 held while port 0 arrives
        a0.in_valid_i = 4'b1000;
        a0.in_data_i  = '0;
        a0.in_data_i[31:24] = 8'h03;
        tick;
        a0.in_valid_i = '0;
        tick;
        a0.in_valid_i = 4'b0001;
        a0.in_data_i[7:0] = 8'h01;
        #1;
        chk("np_ack", 32'(a0.in_ack_o), 32'h1);
        for (int c = 0; c < 10; c++) begin
            chk("np_valid", 32'(a0.out_valid_o), 32'h1);
            chk("np_data", 32'(a0.out_data_o), 32'h03);
            chk("np_port", 32'(a0.out_port_o), 32'h3);
            tick;
            a0.in_valid_i = '0;
        end
        a0.out_pop_i = 1'b1;
        tick;
        a0.out_pop_i = 1'b0;
        chk("np_next_data", 32'(a0.out_data_o), 32'h01);
        chk("np_next_port", 32'(a0.out_port_o), 32'h0);
        a0.out_pop_i = 1'b1;
        tick;
        a0.out_pop_i = 1'b0;
        chk("np_idle", 32'(a0.out_valid_o), 32'h0);

        // simultaneous push/pop on a single-entry FIFO
        a0.in_valid_i = 4'b0001;
        a0.in_data_i  = '0;
        a0.in_data_i[7:0] = 8'h05;
        tick;
        a0.in_valid_i = '0;
        tick;
        chk("pp_data5", 32'(a0.out_data_o), 32'h05);
        a0.out_pop_i  = 1'b1;
        a0.in_valid_i = 4'b0001;
        a0.in_data_i[7:0] = 8'h06;
        #1;
        chk("pp_ack", 32'(a0.in_ack_o), 32'h1);
        tick;
        a0.out_pop_i  = 1'b0;
        a0.in_valid_i = '0;
        chk("pp_gap", 32'(a0.out_valid_o), 32'h0);
        tick;
        chk("pp_valid", 32'(a0.out_valid_o), 32'h1);
        chk("pp_data6", 32'(a0.out_data_o), 32'h06);
        chk("pp_port", 32'(a0.out_port_o), 32'h0);
        a0.out_pop_i = 1'b1;
        tick;
        a0.out_pop_i = 1'b0;
        chk("pp_idle", 32'(a0.out_valid_o), 32'h0);

        // fill port 1 to full, then drain
        a0.in_data_i = '0;
        for (int i = 0; i < 33; i++) begin
            a0.in_valid_i = 4'b0010;
            a0.in_data_i[15:8] = 8'(i);
            #1;
            chk("full_ready", 32'(a0.in_ready_o[1]), 32'(i < 32));
            chk("full_ack", 32'(a0.in_ack_o[1]), 32'(i < 32));
            tick;
        end
        a0.in_valid_i = '0;
        for (int j = 0; j < 32; j++) begin
            chk("drain_data", 32'(a0.out_data_o), 32'(j));
            chk("drain_port", 32'(a0.out_port_o), 32'h1);
            a0.out_pop_i = 1'b1;
            tick;
            if (j == 0)
                chk("drain_ready", 32'(a0.in_ready_o[1]), 32'h1);
        end
        a0.out_pop_i = 1'b0;
        chk("drain_idle", 32'(a0.out_valid_o), 32'h0);

        // 40 more words streamed through with pop held high
        exp_i = 0;
        a0.out_pop_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            a0.in_valid_i = (c < 40) ? 4'b0010 : 4'b0000;
            a0.in_data_i[15:8] = 8'(100 + c);
            #1;
            if (a0.out_valid_o) begin
                chk("wrap_data", 32'(a0.out_data_o), 32'(100 + exp_i));
                exp_i++;
            end
            tick;
        end
        a0.in_valid_i = '0;
        a0.out_pop_i  = 1'b0;
        chk("wrap_count", 32'(exp_i), 32'd40);
        chk("wrap_idle", 32'(a0.out_valid_o), 32'h0);

        // reset while five words are queued and a grant is held
        a0.in_data_i = '0;
        a0.in_data_i[7:0]  = 8'h51;
        a0.in_data_i[15:8] = 8'h61;
        a0.in_valid_i = 4'b0011;
        tick;
        tick;
        a0.in_valid_i = 4'b0001;
        tick;
        a0.in_valid_i = '0;
        chk("mr_valid", 32'(a0.out_valid_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(a0.out_valid_o), 32'h0);
        chk("mr_ready", 32'(a0.in_ready_o), 32'hf);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        a0.out_pop_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("mr_no_stale", 32'(a0.out_valid_o), 32'h0);
            chk("mr_data0", 32'(a0.out_data_o), 32'h0);
            tick;
        end
        a0.out_pop_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
